// File: rtl/uart_peripheral_if.sv
// Register bus between the ulisp core (master) and a register-mapped responder (slave).
interface uart_peripheral_if;
    logic [6:0]  register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;

    modport master (
        output register_index,
        output register_read,
        output register_write,
        output register_write_value,
        input  register_read_value
    );

    modport slave (
        input  register_index,
        input  register_read,
        input  register_write,
        input  register_write_value,
        output register_read_value
    );
endinterface

// File: rtl/uart_peripheral.sv
// UART console on the ulisp register bus: TX FIFO feeding an 8N1 transmitter,
// 8N1 receiver filling a one-byte holding register with overrun/framing status.
module uart_peripheral #(
    parameter int CLKS_PER_BIT  = 16,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_peripheral_if.slave bus,
    output logic             uart_tx,
    input  logic             uart_rx
);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CLK_W-1:0] BIT_LAST   = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] HALF_LAST  = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(TX_FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // Register decode
    logic wr0, wr2, rd0;
    assign wr0 = bus.register_write && (bus.register_index == 7'd0);
    assign wr2 = bus.register_write && (bus.register_index == 7'd2);
    assign rd0 = bus.register_read  && (bus.register_index == 7'd0);

    // Upper write bits carry no meaning for this peripheral
    logic unused_write_bits;
    assign unused_write_bits = ^bus.register_write_value[15:8];

    // TX FIFO
    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tx_full, tx_idle, push, tx_pop;

    assign tx_full = (count == FULL_COUNT);
    assign push    = wr0 && !tx_full;

    // FIFO storage; contents need no reset, validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.register_write_value[7:0];
    end

    // FIFO pointers and occupancy; full is sampled before the edge so a push on full is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, tx_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // TX FSM
    tx_state_t        tx_state, tx_state_next;
    logic [CLK_W-1:0] tx_clk, tx_clk_next;
    logic [2:0]       tx_bit, tx_bit_next;
    logic [7:0]       tx_shift, tx_shift_next;
    logic             tx_line, tx_line_next;

    // TX state register; the line itself is a flop so the pin never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_clk   <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_clk   <= tx_clk_next;
            tx_bit   <= tx_bit_next;
            tx_line  <= tx_line_next;
        end
    end

    // TX shift register (data path, not reset)
    always_ff @(posedge clk) begin
        tx_shift <= tx_shift_next;
    end

    // TX next state: pop on leaving IDLE or straight out of STOP for gapless back-to-back bytes
    always_comb begin
        tx_state_next = tx_state;
        tx_clk_next   = tx_clk + 1'b1;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_line_next  = tx_line;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_clk_next  = '0;
                tx_line_next = 1'b1;
                if (count != '0) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = fifo_mem[rd_ptr];
                    tx_line_next  = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_clk == BIT_LAST) begin
                    tx_clk_next   = '0;
                    tx_bit_next   = '0;
                    tx_line_next  = tx_shift[0];
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_clk == BIT_LAST) begin
                    tx_clk_next = '0;
                    if (tx_bit == 3'd7) begin
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next   = tx_bit + 1'b1;
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        tx_line_next  = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_clk == BIT_LAST) begin
                    tx_clk_next = '0;
                    if (count != '0) begin
                        tx_pop        = 1'b1;
                        tx_shift_next = fifo_mem[rd_ptr];
                        tx_line_next  = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign uart_tx = tx_line;
    assign tx_idle = (count == '0) && (tx_state == TX_IDLE);

    // RX input synchronizer, idles high
    logic rx_meta, rx_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // RX FSM
    rx_state_t        rx_state, rx_state_next;
    logic [CLK_W-1:0] rx_clk, rx_clk_next;
    logic [2:0]       rx_bit, rx_bit_next;
    logic [7:0]       rx_shift, rx_shift_next;
    logic             rx_good, rx_bad;

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_clk   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_clk   <= rx_clk_next;
            rx_bit   <= rx_bit_next;
        end
    end

    // RX shift register (data path, not reset)
    always_ff @(posedge clk) begin
        rx_shift <= rx_shift_next;
    end

    // RX next state: verify start at half bit, then sample each later bit mid-bit
    always_comb begin
        rx_state_next = rx_state;
        rx_clk_next   = rx_clk + 1'b1;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_good       = 1'b0;
        rx_bad        = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_clk_next = '0;
                if (!rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_clk == HALF_LAST) begin
                    rx_clk_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_clk == BIT_LAST) begin
                    rx_clk_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_next = RX_STOP;
                    else                rx_bit_next   = rx_bit + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_clk == BIT_LAST) begin
                    rx_clk_next = '0;
                    if (rx_sync) begin
                        rx_good       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_bad        = 1'b1;
                        rx_state_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_clk_next = '0;
                if (rx_sync) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // RX holding register and sticky errors; a read that coincides with a new byte hands over cleanly
    logic [7:0] rx_data;
    logic       rx_valid, overrun, framing_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (wr2) begin
                overrun     <= 1'b0;
                framing_err <= 1'b0;
            end
            if (rx_bad) framing_err <= 1'b1;
            if (rx_good) begin
                if (!rx_valid || rd0) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd0) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Read data is purely combinational from the index
    always_comb begin
        bus.register_read_value = 16'h0000;
        case (bus.register_index)
            7'd0:    bus.register_read_value = {8'h00, rx_data};
            7'd1:    bus.register_read_value = {11'b0, framing_err, overrun, rx_valid, tx_idle, tx_full};
            default: bus.register_read_value = 16'h0000;
        endcase
    end
endmodule

// File: tb/tb_uart_peripheral.sv
// Testbench for uart_peripheral: scoreboard of TX bytes decoded off the line, RX bytes read back over the bus.
`timescale 1ns/1ps
module tb_uart_peripheral;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    uart_peripheral_if bus_if();

    uart_peripheral #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if.slave),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    int start_q[$];
    int last_wr_cyc = 0;

    // TX line monitor: decodes frames sampled mid-cycle and checks them against the scoreboard
    initial begin : tx_monitor
        logic [FRAME-1:0] samp;
        logic [7:0] got, e;
        logic ab, shape_ok;
        int st;
        forever begin
            @(negedge clk); #2;
            if (!reset && uart_tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                samp = '0;
                samp[0] = uart_tx;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk); #2;
                    if (reset) begin ab = 1'b1; break; end
                    samp[i] = uart_tx;
                end
                if (!ab) begin
                    shape_ok = (samp[0] === 1'b0) && (samp[FRAME-CPB] === 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int k = 1; k < CPB; k++)
                            if (samp[b*CPB+k] !== samp[b*CPB]) shape_ok = 1'b0;
                    for (int b = 0; b < 8; b++) got[b] = samp[(b+1)*CPB];
                    start_q.push_back(st);
                    n_cmp++;
                    if (tx_exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL tx_frame: got byte %02h at cycle %0d, required no frame", got, st);
                    end else begin
                        e = tx_exp_q.pop_front();
                        if (!shape_ok || got !== e) begin
                            n_fail++;
                            $display("FAIL tx_frame: got byte %02h (shape_ok=%0b), required %02h", got, shape_ok, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [6:0] idx, input logic [15:0] val);
        @(negedge clk);
        bus_if.register_index       = idx;
        bus_if.register_write_value = val;
        bus_if.register_write       = 1'b1;
        last_wr_cyc = cyc;
        @(negedge clk);
        bus_if.register_write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] idx, output logic [15:0] val);
        @(negedge clk);
        bus_if.register_index = idx;
        bus_if.register_read  = 1'b1;
        #1 val = bus_if.register_read_value;
        @(negedge clk);
        bus_if.register_read = 1'b0;
    endtask

    task automatic peek(input logic [6:0] idx, output logic [15:0] val);
        @(negedge clk);
        bus_if.register_index = idx;
        #1 val = bus_if.register_read_value;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] v;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx_idle: uart_tx=%b, required 1", uart_tx); end
        end
        @(negedge clk);
        reset = 1'b0;
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL reset_status: got %04h, required 0002", v); end
        peek(7'd0, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_data: got %04h, required 0000", v); end
        peek(7'd9, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read: got %04h, required 0000", v); end
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx: uart_tx=%b, required 1", uart_tx); end
    endtask

    task automatic test_tx_single;
        logic [15:0] v;
        int n, wcyc;
        start_q.delete();
        tx_exp_q.push_back(8'h41);
        bus_write(7'd0, 16'h1241);
        wcyc = last_wr_cyc;
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL tx_busy_status: got %04h, required 0000", v); end
        n = 0;
        while (tx_exp_q.size() != 0 && n < 3 * FRAME) begin @(negedge clk); n++; end
        n_cmp++;
        if (tx_exp_q.size() != 0) begin
            n_fail++; $display("FAIL tx_single_drain: %0d bytes pending, required 0", tx_exp_q.size());
            tx_exp_q.delete();
        end
        n_cmp++;
        if (start_q.size() != 1 || start_q[0] - wcyc != 2) begin
            n_fail++;
            $display("FAIL tx_start_latency: frames=%0d latency=%0d, required 1 frame latency 2",
                     start_q.size(), (start_q.size() > 0) ? start_q[0] - wcyc : -1);
        end
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL tx_idle_after: got %04h, required 0002", v); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        int n;
        logic gaps_ok;
        start_q.delete();
        @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            bus_if.register_index       = 7'd0;
            bus_if.register_write_value = 16'(i);
            bus_if.register_write       = 1'b1;
            if (i <= 5) tx_exp_q.push_back(8'(i));
            @(negedge clk);
        end
        bus_if.register_write = 1'b0;
        bus_if.register_index = 7'd1;
        #1 v = bus_if.register_read_value;
        n_cmp++;
        if (v !== 16'h0001) begin n_fail++; $display("FAIL fifo_full_status: got %04h, required 0001", v); end
        n = 0;
        while (tx_exp_q.size() != 0 && n < 7 * FRAME) begin @(negedge clk); n++; end
        n_cmp++;
        if (tx_exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: %0d bytes pending, required 0", tx_exp_q.size());
            tx_exp_q.delete();
        end
        repeat (2 * FRAME) @(negedge clk);
        gaps_ok = (start_q.size() == 5);
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != FRAME) gaps_ok = 1'b0;
        n_cmp++;
        if (!gaps_ok) begin
            n_fail++; $display("FAIL b2b_spacing: frames=%0d gapless=%0b, required 5 frames %0d cycles apart",
                               start_q.size(), gaps_ok, FRAME);
        end
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL b2b_idle_after: got %04h, required 0002", v); end
    endtask

    task automatic test_rx_basic;
        logic [15:0] v;
        logic [7:0] e;
        rx_exp_q.push_back(8'h5A);
        send_rx(8'h5A, 1'b1);
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0006) begin n_fail++; $display("FAIL rx_valid_status: got %04h, required 0006", v); end
        bus_read(7'd0, v);
        e = rx_exp_q.pop_front();
        n_cmp++;
        if (v !== {8'h00, e}) begin n_fail++; $display("FAIL rx_data: got %04h, required %04h", v, {8'h00, e}); end
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL rx_valid_cleared: got %04h, required 0002", v); end
        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        repeat (3 * FRAME) @(negedge clk);
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL rx_glitch_status: got %04h, required 0002", v); end
        peek(7'd0, v);
        n_cmp++;
        if (v !== 16'h005A) begin n_fail++; $display("FAIL rx_glitch_data: got %04h, required 005a", v); end
    endtask

    task automatic test_overrun;
        logic [15:0] v;
        logic [7:0] e;
        rx_exp_q.push_back(8'h11);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h000E) begin n_fail++; $display("FAIL overrun_status: got %04h, required 000e", v); end
        bus_read(7'd0, v);
        e = rx_exp_q.pop_front();
        n_cmp++;
        if (v !== {8'h00, e}) begin n_fail++; $display("FAIL overrun_data: got %04h, required %04h", v, {8'h00, e}); end
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h000A) begin n_fail++; $display("FAIL overrun_after_read: got %04h, required 000a", v); end
        bus_write(7'd2, 16'hFFFF);
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL overrun_clear: got %04h, required 0002", v); end
    endtask

    task automatic test_framing_and_reset;
        logic [15:0] v;
        logic stayed_high;
        send_rx(8'h33, 1'b0);
        repeat (4) @(negedge clk);
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0012) begin n_fail++; $display("FAIL framing_status: got %04h, required 0012", v); end
        bus_write(7'd2, 16'h0000);
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL framing_clear: got %04h, required 0002", v); end
        bus_write(7'd0, 16'h0055);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_abort_tx: uart_tx=%b, required 1", uart_tx); end
        @(negedge clk);
        reset = 1'b0;
        peek(7'd1, v);
        n_cmp++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL reset_abort_status: got %04h, required 0002", v); end
        stayed_high = 1'b1;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stayed_high = 1'b0;
        end
        n_cmp++;
        if (!stayed_high) begin n_fail++; $display("FAIL reset_abort_line: uart_tx left idle, required steady 1"); end
    endtask

    initial begin
        bus_if.register_index       = 7'd0;
        bus_if.register_read        = 1'b0;
        bus_if.register_write       = 1'b0;
        bus_if.register_write_value = 16'h0000;
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_basic();
        test_overrun();
        test_framing_and_reset();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
